// File: rtl/rename_if.sv
// rename_if: decode-side rename request, wakeup/free inputs and renamed operand results
interface rename_if;
   logic        wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active;
   logic [5:0]  wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag;
   logic [31:0] wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value;
   logic [5:0]  freed_tag_1, freed_tag_2;
   logic        is_instruction_valid;
   logic [4:0]  architectural_rd, architectural_rs1, architectural_rs2;
   logic [5:0]  physical_rd, physical_rs1, physical_rs2;
   logic        rs1_ready, rs2_ready;
   logic [31:0] rs1_value, rs2_value;
   logic        free_list_empty;
   modport master (
      output wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active,
      output wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag,
      output wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value,
      output freed_tag_1, freed_tag_2, is_instruction_valid,
      output architectural_rd, architectural_rs1, architectural_rs2,
      input  physical_rd, physical_rs1, physical_rs2,
      input  rs1_ready, rs2_ready, rs1_value, rs2_value, free_list_empty
   );
   modport slave (
      input  wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active,
      input  wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag,
      input  wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value,
      input  freed_tag_1, freed_tag_2, is_instruction_valid,
      input  architectural_rd, architectural_rs1, architectural_rs2,
      output physical_rd, physical_rs1, physical_rs2,
      output rs1_ready, rs2_ready, rs1_value, rs2_value, free_list_empty
   );
endinterface

// File: rtl/rename_unit.sv
// rename_unit: RAT lookup, free-list tag allocation and physical register file with wakeup bypass
module rename_unit (
   input logic     clk,
   input logic     reset,
   rename_if.slave rif
);
   logic [5:0]  rat [32];
   logic [63:0] ready;
   logic [31:0] regs [64];
   logic [5:0]  fl [64];
   logic [5:0]  head, tail, tail2;
   logic [6:0]  count, base;
   logic [3:0]  wk_act;
   logic [5:0]  wk_tag [4];
   logic [31:0] wk_val [4];
   logic [5:0]  p1, p2;
   logic        alloc, push1, push2;
   assign wk_act = {rif.wakeup_3_active, rif.wakeup_2_active, rif.wakeup_1_active, rif.wakeup_0_active};
   assign wk_tag[0] = rif.wakeup_0_tag;
   assign wk_tag[1] = rif.wakeup_1_tag;
   assign wk_tag[2] = rif.wakeup_2_tag;
   assign wk_tag[3] = rif.wakeup_3_tag;
   assign wk_val[0] = rif.wakeup_0_value;
   assign wk_val[1] = rif.wakeup_1_value;
   assign wk_val[2] = rif.wakeup_2_value;
   assign wk_val[3] = rif.wakeup_3_value;
   assign p1 = rat[rif.architectural_rs1];
   assign p2 = rat[rif.architectural_rs2];
   assign rif.physical_rs1 = p1;
   assign rif.physical_rs2 = p2;
   assign alloc = rif.is_instruction_valid && rif.architectural_rd != 5'd0 && count != 7'd0;
   assign rif.physical_rd = alloc ? fl[head] : 6'd0;
   assign rif.free_list_empty = count == 7'd0;
   // pushes see the room left after this edge's pop; overflow pushes are dropped
   assign base = count - {6'd0, alloc};
   assign push1 = rif.freed_tag_1 != 6'd0 && base != 7'd64;
   assign push2 = rif.freed_tag_2 != 6'd0 && (base + {6'd0, push1}) < 7'd64;
   assign tail2 = tail + {5'd0, push1};
   // descending scan so the lowest matching wakeup port ends up driving the bypass
   always_comb begin
      rif.rs1_ready = ready[p1];
      rif.rs1_value = regs[p1];
      rif.rs2_ready = ready[p2];
      rif.rs2_value = regs[p2];
      for (int i = 3; i >= 0; i--) begin
         if (wk_act[i] && wk_tag[i] != 6'd0 && wk_tag[i] == p1) begin
            rif.rs1_ready = 1'b1;
            rif.rs1_value = wk_val[i];
         end
         if (wk_act[i] && wk_tag[i] != 6'd0 && wk_tag[i] == p2) begin
            rif.rs2_ready = 1'b1;
            rif.rs2_value = wk_val[i];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rat[i] <= 6'(i);
         for (int i = 0; i < 64; i++) begin
            regs[i] <= 32'd0;
            fl[i] <= 6'(i);
         end
         ready <= '1;
         head <= 6'd32;
         tail <= 6'd0;
         count <= 7'd32;
      end else begin
         for (int i = 3; i >= 0; i--)
            if (wk_act[i] && wk_tag[i] != 6'd0) begin
               regs[wk_tag[i]] <= wk_val[i];
               ready[wk_tag[i]] <= 1'b1;
            end
         // placed after wakeup so the allocation clear wins on a shared tag
         if (alloc) begin
            rat[rif.architectural_rd] <= fl[head];
            ready[fl[head]] <= 1'b0;
         end
         if (push1) fl[tail] <= rif.freed_tag_1;
         if (push2) fl[tail2] <= rif.freed_tag_2;
         head <= head + {5'd0, alloc};
         tail <= tail2 + {5'd0, push2};
         count <= base + {6'd0, push1} + {6'd0, push2};
      end
   end
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed and random rename traffic checked against a queue-based reference model
module tb_rename_unit;
   logic clk = 0;
   logic reset;
   int vectors = 0, errors = 0;
   logic        w_act [4];
   logic [5:0]  w_tag [4];
   logic [31:0] w_val [4];
   logic [5:0]  m_rat [32];
   bit          m_rdy [64];
   logic [31:0] m_val [64];
   logic [5:0]  m_fl [$];
   rename_if rif ();
   rename_unit u_dut (.clk(clk), .reset(reset), .rif(rif));
   always #5 clk = ~clk;
   assign rif.wakeup_0_active = w_act[0];
   assign rif.wakeup_1_active = w_act[1];
   assign rif.wakeup_2_active = w_act[2];
   assign rif.wakeup_3_active = w_act[3];
   assign rif.wakeup_0_tag = w_tag[0];
   assign rif.wakeup_1_tag = w_tag[1];
   assign rif.wakeup_2_tag = w_tag[2];
   assign rif.wakeup_3_tag = w_tag[3];
   assign rif.wakeup_0_value = w_val[0];
   assign rif.wakeup_1_value = w_val[1];
   assign rif.wakeup_2_value = w_val[2];
   assign rif.wakeup_3_value = w_val[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic idle();
      for (int p = 0; p < 4; p++) begin
         w_act[p] = 0;
         w_tag[p] = 0;
         w_val[p] = 0;
      end
      rif.freed_tag_1 = 0;
      rif.freed_tag_2 = 0;
      rif.is_instruction_valid = 0;
      rif.architectural_rd = 0;
      rif.architectural_rs1 = 0;
      rif.architectural_rs2 = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
      for (int i = 0; i < 64; i++) begin
         m_rdy[i] = 1;
         m_val[i] = 0;
      end
      m_fl.delete();
      for (int i = 32; i < 64; i++) m_fl.push_back(6'(i));
   endtask

   function automatic void model_src(input logic [4:0] rs, output logic [5:0] t, output logic r, output logic [31:0] v);
      t = (rs == 0) ? 6'd0 : m_rat[rs];
      r = m_rdy[t];
      v = m_val[t];
      if (t != 0)
         for (int p = 0; p < 4; p++)
            if (w_act[p] && w_tag[p] == t) begin
               r = 1;
               v = w_val[p];
               break;
            end
   endfunction

   function automatic bit will_alloc();
      return rif.is_instruction_valid && rif.architectural_rd != 0 && m_fl.size() > 0;
   endfunction

   task automatic model_update();
      logic [5:0] t;
      bit done [64];
      if (!reset) begin
         model_reset();
         return;
      end
      t = 0;
      if (will_alloc()) t = m_fl.pop_front();
      for (int p = 0; p < 4; p++)
         if (w_act[p] && w_tag[p] != 0 && !done[w_tag[p]]) begin
            done[w_tag[p]] = 1;
            m_val[w_tag[p]] = w_val[p];
            m_rdy[w_tag[p]] = 1;
         end
      if (t != 0) begin
         m_rat[rif.architectural_rd] = t;
         m_rdy[t] = 0;
      end
      if (rif.freed_tag_1 != 0 && m_fl.size() < 64) m_fl.push_back(rif.freed_tag_1);
      if (rif.freed_tag_2 != 0 && m_fl.size() < 64) m_fl.push_back(rif.freed_tag_2);
   endtask

   task automatic step();
      logic [5:0] t1, t2;
      logic r1, r2;
      logic [31:0] v1, v2;
      #1;
      model_src(rif.architectural_rs1, t1, r1, v1);
      model_src(rif.architectural_rs2, t2, r2, v2);
      check("physical_rd", 32'(rif.physical_rd), will_alloc() ? 32'(m_fl[0]) : 32'd0);
      check("physical_rs1", 32'(rif.physical_rs1), 32'(t1));
      check("physical_rs2", 32'(rif.physical_rs2), 32'(t2));
      check("rs1_ready", 32'(rif.rs1_ready), 32'(r1));
      check("rs2_ready", 32'(rif.rs2_ready), 32'(r2));
      if (r1) check("rs1_value", rif.rs1_value, v1);
      if (r2) check("rs2_value", rif.rs2_value, v2);
      check("free_list_empty", 32'(rif.free_list_empty), 32'(m_fl.size() == 0));
      @(posedge clk);
      model_update();
      #2;
   endtask

   task automatic instr(input bit valid, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      rif.is_instruction_valid = valid;
      rif.architectural_rd = rd;
      rif.architectural_rs1 = rs1;
      rif.architectural_rs2 = rs2;
   endtask

   initial begin
      idle();
      reset = 0;
      @(posedge clk);
      model_reset();
      #2;
      reset = 1;
      instr(1, 1, 0, 1);
      #1;
      check("plan_rd_first", 32'(rif.physical_rd), 32'd32);
      check("plan_prs2_reset", 32'(rif.physical_rs2), 32'd1);
      check("plan_rs2_ready_reset", 32'(rif.rs2_ready), 32'd1);
      step();
      #1;
      check("plan_rd_second", 32'(rif.physical_rd), 32'd33);
      check("plan_prs2_renamed", 32'(rif.physical_rs2), 32'd32);
      check("plan_rs2_busy", 32'(rif.rs2_ready), 32'd0);
      step();
      instr(1, 0, 0, 1);
      w_act[0] = 1; w_tag[0] = 32; w_val[0] = 123;
      #1;
      check("plan_rd_x0", 32'(rif.physical_rd), 32'd0);
      check("plan_prs2_33", 32'(rif.physical_rs2), 32'd33);
      step();
      w_tag[0] = 33; w_val[0] = 456;
      #1;
      check("plan_bypass", rif.rs2_value, 32'd456);
      step();
      w_act[0] = 0;
      #1;
      check("plan_persist", rif.rs2_value, 32'd456);
      step();
      instr(1, 2, 0, 2);
      step();
      instr(0, 0, 2, 2);
      w_act[3] = 1; w_tag[3] = m_rat[2]; w_val[3] = 32'hCAFE;
      #1;
      check("plan_port3_bypass", rif.rs2_value, 32'hCAFE);
      step();
      w_act[3] = 0;
      for (int i = 0; i < 64 && m_fl.size() > 0; i++) begin
         instr(1, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
         step();
      end
      #1;
      check("plan_empty", 32'(rif.free_list_empty), 32'd1);
      check("plan_empty_rd", 32'(rif.physical_rd), 32'd0);
      step();
      instr(0, 0, 0, 0);
      rif.freed_tag_1 = 5; rif.freed_tag_2 = 7;
      step();
      rif.freed_tag_1 = 0; rif.freed_tag_2 = 0;
      instr(1, 3, 3, 4);
      #1;
      check("plan_reuse_5", 32'(rif.physical_rd), 32'd5);
      step();
      #1;
      check("plan_reuse_7", 32'(rif.physical_rd), 32'd7);
      step();
      for (int c = 0; c < 1600; c++) begin
         bit heavy;
         heavy = (c % 400) >= 200;
         reset = ($urandom_range(0, 299) != 0);
         instr($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom), 5'($urandom));
         for (int p = 0; p < 4; p++) begin
            w_act[p] = $urandom_range(0, 2) == 0;
            w_tag[p] = $urandom_range(0, 1) ? m_rat[5'($urandom)] : 6'($urandom);
            w_val[p] = $urandom;
         end
         rif.freed_tag_1 = (heavy ? $urandom_range(0, 1) : $urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
         rif.freed_tag_2 = (heavy ? $urandom_range(0, 1) : $urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
